// File: rtl/sargantana_icache_pkg.sv
// Shared types and sizes for the Sargantana instruction cache refill path.
package sargantana_icache_pkg;

  localparam int PHY_ADDR_SIZE       = 40;
  localparam int ICACHE_N_WAY        = 4;
  localparam int ICACHE_IDX_WIDTH    = 6;
  localparam int ICACHE_OFFSET_WIDTH = 6;
  localparam int ICACHE_TAG_WIDTH    = PHY_ADDR_SIZE - ICACHE_IDX_WIDTH - ICACHE_OFFSET_WIDTH;
  localparam int SET_WIDHT           = 512;
  localparam int ICACHE_WAY_WIDTH    = $clog2(ICACHE_N_WAY);

  // Invalidation sideband carried on the IFILL response.
  typedef struct packed {
    logic                     valid;
    logic [PHY_ADDR_SIZE-1:0] paddr;
  } ifill_inv_t;

  // Line fill request toward the L2.
  typedef struct packed {
    logic                        valid;
    logic [ICACHE_WAY_WIDTH-1:0] way;
    logic [PHY_ADDR_SIZE-1:0]    paddr;
  } ifill_req_o_t;

  // Line fill response from the L2: ack closes the request, valid carries data.
  typedef struct packed {
    logic [SET_WIDHT-1:0] data;
    logic                 ack;
    logic                 valid;
    ifill_inv_t           inv;
  } ifill_resp_i_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  // Binary way number to one-hot way select.
  function automatic logic [ICACHE_N_WAY-1:0] way_onehot(input logic [ICACHE_WAY_WIDTH-1:0] way);
    way_onehot = ICACHE_N_WAY'(1) << way;
  endfunction

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Victim way choice: first invalid way, else a round-robin pointer that
// advances only on misses that actually used it.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ICACHE_N_WAY-1:0]     way_valid,
  input  logic                        take,
  output logic [ICACHE_WAY_WIDTH-1:0] victim_bin,
  output logic [ICACHE_N_WAY-1:0]     victim_oh
);

  logic [ICACHE_WAY_WIDTH-1:0] rr_q;
  logic [ICACHE_WAY_WIDTH-1:0] first_free;
  logic                        all_valid;

  // Lowest-index invalid way wins; a full set falls back to the pointer.
  always_comb begin
    all_valid  = &way_valid;
    first_free = '0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (!way_valid[i]) first_free = ICACHE_WAY_WIDTH'(i);
    end
    victim_bin = all_valid ? rr_q : first_free;
    victim_oh  = way_onehot(victim_bin);
  end

  // Round-robin pointer, modulo the way count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (take && all_valid) begin
      rr_q <= (rr_q == ICACHE_WAY_WIDTH'(ICACHE_N_WAY - 1)) ? '0 : rr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sargantana_icache_refill_ctrl.sv
// Icache miss-refill sequencer: one outstanding line fill, victim choice,
// array write-back and invalidation forwarding.
//
// Handshakes: a miss transfers on a cycle where miss_valid_i and miss_ready_o
// are both high. The IFILL request holds valid, way and paddr stable from the
// cycle after acceptance until the cycle ifill_resp_i.ack is seen, and is never
// withdrawn early. Response data is taken on the first cycle with
// ifill_resp_i.valid at or after the ack cycle.
module sargantana_icache_refill_ctrl
  import sargantana_icache_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        miss_valid_i,
  input  logic [PHY_ADDR_SIZE-1:0]    miss_paddr_i,
  output logic                        miss_ready_o,
  input  logic [ICACHE_N_WAY-1:0]     way_valid_i,
  input  logic                        kill_i,
  output ifill_req_o_t                ifill_req_o,
  input  ifill_resp_i_t               ifill_resp_i,
  output logic                        wr_en_o,
  output logic [ICACHE_N_WAY-1:0]     wr_way_o,
  output logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o,
  output logic [ICACHE_TAG_WIDTH-1:0] wr_tag_o,
  output logic [SET_WIDHT-1:0]        wr_data_o,
  output logic                        inv_en_o,
  output logic [ICACHE_IDX_WIDTH-1:0] inv_idx_o,
  output logic                        done_o,
  output logic                        busy_o,
  output refill_state_t               state_o
);

  localparam int OFF_W = ICACHE_OFFSET_WIDTH;
  localparam int IDX_W = ICACHE_IDX_WIDTH;

  refill_state_t               state_q, state_d;
  logic [PHY_ADDR_SIZE-1:0]    line_q;
  logic [ICACHE_WAY_WIDTH-1:0] way_q;
  logic [ICACHE_N_WAY-1:0]     way_oh_q;
  logic [SET_WIDHT-1:0]        data_q;
  logic                        stale_q, killed_q;
  logic                        inv_en_q;
  logic [IDX_W-1:0]            inv_idx_q;

  logic                        accept, in_flight, capture;
  logic [IDX_W-1:0]            inv_idx, line_idx;
  logic [ICACHE_WAY_WIDTH-1:0] victim_bin;
  logic [ICACHE_N_WAY-1:0]     victim_oh;
  logic                        unused_bits;

  // Offset bits and the invalidation tag never matter here.
  assign unused_bits = ^{miss_paddr_i[OFF_W-1:0],
                         ifill_resp_i.inv.paddr[PHY_ADDR_SIZE-1:OFF_W+IDX_W],
                         ifill_resp_i.inv.paddr[OFF_W-1:0]};

  assign accept    = (state_q == IDLE) && miss_valid_i;
  assign in_flight = (state_q == REQ) || (state_q == WAIT);
  assign capture   = ((state_q == REQ) && ifill_resp_i.ack && ifill_resp_i.valid) ||
                     ((state_q == WAIT) && ifill_resp_i.valid);
  assign inv_idx   = ifill_resp_i.inv.paddr[OFF_W+IDX_W-1:OFF_W];
  assign line_idx  = line_q[OFF_W+IDX_W-1:OFF_W];

  sargantana_icache_victim_sel u_victim_sel (
    .clk        (clk_i),
    .rst        (rst_i),
    .way_valid  (way_valid_i),
    .take       (accept),
    .victim_bin (victim_bin),
    .victim_oh  (victim_oh)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (miss_valid_i) state_d = REQ;
      REQ:   if (ifill_resp_i.ack) state_d = ifill_resp_i.valid ? WRITE : WAIT;
      WAIT:  if (ifill_resp_i.valid) state_d = WRITE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Refill context, kill/stale flags, captured line and registered invalidation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q    <= '0;
      way_q     <= '0;
      way_oh_q  <= '0;
      data_q    <= '0;
      stale_q   <= 1'b0;
      killed_q  <= 1'b0;
      inv_en_q  <= 1'b0;
      inv_idx_q <= '0;
    end else begin
      inv_en_q <= ifill_resp_i.inv.valid;
      if (ifill_resp_i.inv.valid) inv_idx_q <= inv_idx;
      if (accept) begin
        line_q   <= {miss_paddr_i[PHY_ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        way_q    <= victim_bin;
        way_oh_q <= victim_oh;
        stale_q  <= 1'b0;
        killed_q <= 1'b0;
      end
      if (in_flight && kill_i) killed_q <= 1'b1;
      // An invalidation seen during WRITE lands after the write, so only
      // in-flight refills are marked stale.
      if (in_flight && ifill_resp_i.inv.valid && (inv_idx == line_idx)) stale_q <= 1'b1;
      if (capture) data_q <= ifill_resp_i.data;
    end
  end

  // Outputs decoded from state and latched context.
  always_comb begin
    ifill_req_o       = '0;
    ifill_req_o.valid = (state_q == REQ);
    ifill_req_o.way   = way_q;
    ifill_req_o.paddr = line_q;
    miss_ready_o      = (state_q == IDLE);
    busy_o            = (state_q != IDLE);
    wr_en_o           = (state_q == WRITE) && !stale_q && !killed_q;
    done_o            = (state_q == WRITE) && !killed_q;
    wr_way_o          = way_oh_q;
    wr_idx_o          = line_idx;
    wr_tag_o          = line_q[PHY_ADDR_SIZE-1:OFF_W+IDX_W];
    wr_data_o         = data_q;
    inv_en_o          = inv_en_q;
    inv_idx_o         = inv_idx_q;
    state_o           = state_q;
  end

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Directed cycle-vector bench for the icache refill sequencer.
module tb_sargantana_icache_refill_ctrl;
  import sargantana_icache_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic                        miss_valid;
  logic [PHY_ADDR_SIZE-1:0]    miss_paddr;
  logic                        miss_ready;
  logic [ICACHE_N_WAY-1:0]     way_valid;
  logic                        kill;
  ifill_req_o_t                ifill_req;
  ifill_resp_i_t               ifill_resp;
  logic                        wr_en;
  logic [ICACHE_N_WAY-1:0]     wr_way;
  logic [ICACHE_IDX_WIDTH-1:0] wr_idx;
  logic [ICACHE_TAG_WIDTH-1:0] wr_tag;
  logic [SET_WIDHT-1:0]        wr_data;
  logic                        inv_en;
  logic [ICACHE_IDX_WIDTH-1:0] inv_idx;
  logic                        done;
  logic                        busy;
  refill_state_t               state;

  sargantana_icache_refill_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .miss_valid_i (miss_valid),
    .miss_paddr_i (miss_paddr),
    .miss_ready_o (miss_ready),
    .way_valid_i  (way_valid),
    .kill_i       (kill),
    .ifill_req_o  (ifill_req),
    .ifill_resp_i (ifill_resp),
    .wr_en_o      (wr_en),
    .wr_way_o     (wr_way),
    .wr_idx_o     (wr_idx),
    .wr_tag_o     (wr_tag),
    .wr_data_o    (wr_data),
    .inv_en_o     (inv_en),
    .inv_idx_o    (inv_idx),
    .done_o       (done),
    .busy_o       (busy),
    .state_o      (state)
  );

  // one record per clock cycle: inputs driven, outputs expected that cycle
  typedef struct {
    logic        mv;
    logic [39:0] pa;
    logic [3:0]  wv;
    logic        kill, ack, rv, invv;
    logic [39:0] ipa;
    logic        e_ready, e_reqv, e_wr, e_done, e_inv;
    logic [5:0]  e_iidx;
    logic [1:0]  e_way;
    logic [39:0] e_line;
    logic [5:0]  e_idx;
    logic [27:0] e_tag;
  } vec_t;

  vec_t        tbl[$];
  logic [1:0]  c_way;
  logic [39:0] c_line;
  logic [5:0]  c_idx;
  logic [27:0] c_tag;

  int n_vec  = 0;
  int n_fail = 0;

  // scoreboard compare
  task automatic chk(input string name, input int id, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h want %0h", name, id, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic void ctx(input logic [1:0] way, input logic [39:0] line,
                              input logic [5:0] idx, input logic [27:0] tag);
    c_way = way; c_line = line; c_idx = idx; c_tag = tag;
  endfunction

  function automatic void add(input logic mv, input logic [39:0] pa, input logic [3:0] wv,
                              input logic k, input logic ack, input logic rv,
                              input logic invv, input logic [39:0] ipa,
                              input logic er, input logic eq, input logic ew,
                              input logic ed, input logic ei, input logic [5:0] eii);
    vec_t v;
    v.mv = mv; v.pa = pa; v.wv = wv; v.kill = k; v.ack = ack; v.rv = rv;
    v.invv = invv; v.ipa = ipa;
    v.e_ready = er; v.e_reqv = eq; v.e_wr = ew; v.e_done = ed; v.e_inv = ei; v.e_iidx = eii;
    v.e_way = c_way; v.e_line = c_line; v.e_idx = c_idx; v.e_tag = c_tag;
    tbl.push_back(v);
  endfunction

  // accept, ack+data in the first request cycle, write: minimum turnaround
  function automatic void fast_miss(input logic [39:0] pa, input logic [3:0] wv,
                                    input logic [1:0] way, input logic [39:0] line,
                                    input logic [5:0] idx, input logic [27:0] tag,
                                    input logic invv, input logic [39:0] ipa);
    ctx(way, line, idx, tag);
    add(1, pa, wv, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0,  0,  0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0,  0,  0, 0, 0, invv, ipa, 0, 0, 1, 1, 0, 0);
  endfunction

  // driver tasks
  task automatic drive_idle();
    miss_valid = 1'b0; miss_paddr = '0; way_valid = '0; kill = 1'b0;
    ifill_resp = '0;
  endtask

  task automatic apply(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge clk);
    miss_valid           = v.mv;
    miss_paddr           = v.pa;
    way_valid            = v.wv;
    kill                 = v.kill;
    ifill_resp.ack       = v.ack;
    ifill_resp.valid     = v.rv;
    ifill_resp.inv.valid = v.invv;
    ifill_resp.inv.paddr = v.ipa;
    ifill_resp.data      = pat(i);
    #1;
    chk("miss_ready", i, miss_ready, v.e_ready);
    chk("busy", i, busy, !v.e_ready);
    chk("req_valid", i, ifill_req.valid, v.e_reqv);
    chk("wr_en", i, wr_en, v.e_wr);
    chk("done", i, done, v.e_done);
    chk("inv_en", i, inv_en, v.e_inv);
    if (v.e_reqv) begin
      chk("req_paddr", i, ifill_req.paddr, v.e_line);
      chk("req_way", i, ifill_req.way, v.e_way);
    end
    if (v.e_wr) begin
      chk("wr_way", i, wr_way, 4'b0001 << v.e_way);
      chk("wr_idx", i, wr_idx, v.e_idx);
      chk("wr_tag", i, wr_tag, v.e_tag);
      chk("wr_data", i, wr_data, pat(i - 1));
    end
    if (v.e_inv) chk("inv_idx", i, inv_idx, v.e_iidx);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_ready", -1, miss_ready, 1'b1);
    chk("rst_busy", -1, busy, 1'b0);
    chk("rst_req_valid", -1, ifill_req.valid, 1'b0);
    chk("rst_req_paddr", -1, ifill_req.paddr, 40'h0);
    chk("rst_wr_en", -1, wr_en, 1'b0);
    chk("rst_done", -1, done, 1'b0);
    chk("rst_inv_en", -1, inv_en, 1'b0);
    chk("rst_state", -1, state, IDLE);

    // cold miss 0x1058: ack 3 cycles into the request, data 2 cycles later
    ctx(0, 40'h1040, 6'd1, 28'h1);
    add(1, 40'h1058, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);

    // full set, back-to-back: round-robin 0,1,2,3,0
    fast_miss(40'h3000, 4'b1111, 0, 40'h3000, 6'd0, 28'h3, 0, 0);
    fast_miss(40'h3040, 4'b1111, 1, 40'h3040, 6'd1, 28'h3, 0, 0);
    fast_miss(40'h3080, 4'b1111, 2, 40'h3080, 6'd2, 28'h3, 0, 0);
    fast_miss(40'h30C0, 4'b1111, 3, 40'h30C0, 6'd3, 28'h3, 0, 0);
    fast_miss(40'h3100, 4'b1111, 0, 40'h3100, 6'd4, 28'h3, 0, 0);
    // free way 2 used, pointer left at 1
    fast_miss(40'h3140, 4'b1011, 2, 40'h3140, 6'd5, 28'h3, 0, 0);
    fast_miss(40'h3180, 4'b1111, 1, 40'h3180, 6'd6, 28'h3, 0, 0);

    // kill in WAIT: response consumed, nothing written
    ctx(1, 40'h5080, 6'd2, 28'h5);
    add(1, 40'h5080, 4'b0001, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // invalidate idx 1 while waiting on idx 1: stale, done still pulses
    ctx(2, 40'h1040, 6'd1, 28'h1);
    add(1, 40'h1058, 4'b0011, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 40'h7040,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 6'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);

    // invalidate idx 2 while waiting on idx 1: normal write
    add(1, 40'h1058, 4'b0011, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 40'h0080,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 6'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);

    // invalidation during WRITE to the same idx lands after the write
    fast_miss(40'h1058, 4'b0000, 0, 40'h1040, 6'd1, 28'h1, 1, 40'h1040);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 6'd1);

    // kill alongside acceptance in IDLE is ignored
    ctx(0, 40'h9FC0, 6'd63, 28'h9);
    add(1, 40'h9FFF, 4'b0000, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(i);

    // reset while waiting, then a late response
    @(negedge clk);
    drive_idle();
    miss_valid = 1'b1; miss_paddr = 40'h2040;
    @(negedge clk);
    drive_idle();
    ifill_resp.ack = 1'b1;
    @(negedge clk);
    drive_idle();
    #1;
    chk("wait_busy", -2, busy, 1'b1);
    chk("wait_state", -2, state, WAIT);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", -2, miss_ready, 1'b1);
    chk("mid_rst_req_valid", -2, ifill_req.valid, 1'b0);
    chk("mid_rst_wr_idx", -2, wr_idx, 6'd0);
    ifill_resp.valid = 1'b1;
    ifill_resp.data  = pat(99);
    @(negedge clk);
    drive_idle();
    #1;
    chk("late_wr_en", -2, wr_en, 1'b0);
    chk("late_done", -2, done, 1'b0);
    chk("late_ready", -2, miss_ready, 1'b1);
    chk("late_req_valid", -2, ifill_req.valid, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill_ctrl.md
# sargantana_icache_refill_ctrl

Miss-refill sequencer for the Sargantana instruction cache. It accepts one line miss at a time from the icache front-end control and selects a victim way. It drives the IFILL request/response handshake toward the L2, writes the returned line and tag into the data/tag arrays, and applies IFILL invalidations. It sits between the icache control FSM and the `ifill_req_o_t`/`ifill_resp_i_t` port of the cache.

## Interface
- `N_WAY`, `ICACHE_N_WAY` (4): number of ways.
- `IDX_W`, `ICACHE_IDX_WIDTH` (6): set index width.
- `OFF_W`, `ICACHE_OFFSET_WIDTH` (6): line offset width.
- `TAG_W`, `ICACHE_TAG_WIDTH`: tag width, equal to `PHY_ADDR_SIZE - IDX_W - OFF_W`.
- `LINE_W`, `SET_WIDHT` (512): line width in bits.
- Reset: one clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous reset, active-high.
- `miss_valid_i` in 1: miss request from icache control.
- `miss_paddr_i` in `PHY_ADDR_SIZE`: physical address of the miss.
- `miss_ready_o` out 1: refill controller is idle and can take a miss.
- `way_valid_i` in `N_WAY`: valid bits of the indexed set, sampled at miss acceptance.
- `kill_i` in 1: abort the current refill.
- `ifill_req_o` out `ifill_req_o_t`: IFILL request.
- `ifill_resp_i` in `ifill_resp_i_t`: IFILL response plus invalidation.
- `wr_en_o` out 1: line/tag write strobe.
- `wr_way_o` out `N_WAY`: one-hot way select.
- `wr_idx_o` out `IDX_W`: set index of the write.
- `wr_tag_o` out `TAG_W`: tag to write.
- `wr_data_o` out `LINE_W`: line data to write.
- `inv_en_o` out 1: invalidate all ways of `inv_idx_o`.
- `inv_idx_o` out `IDX_W`: set index to invalidate.
- `done_o` out 1: one-cycle pulse marking the end of a non-killed refill.
- `busy_o` out 1: asserted whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: a miss is accepted when `miss_valid_i & miss_ready_o`. Latch the line address (`paddr` with low `OFF_W` bits zeroed) and the victim way. Clear `stale` and `killed`. Go to REQ.
  - REQ: `ifill_req_o.valid`=1 and is held until `ifill_resp_i.ack`. It is never withdrawn, even on kill.
    - On ack with `resp.valid` in the same cycle: go to WRITE.
    - On ack otherwise: go to WAIT.
  - WAIT: on `resp.valid`, capture data and go to WRITE.
  - WRITE: one cycle. `wr_en_o`=1 unless `stale|killed`. `done_o`=1 unless `killed`. Go to IDLE.
- `kill_i` in REQ or WAIT sets `killed`. The response is still awaited and then discarded: no write, no `done_o`.
- `kill_i` in WRITE or IDLE is ignored.
- Victim selection:
  - Lowest-index way with `way_valid_i`=0.
  - If all ways are valid, use the round-robin pointer `rr`. `rr` increments modulo `N_WAY` on every accepted miss that used it.
- `ifill_req_o.way` carries the binary encoding of the victim; `wr_way_o` is its one-hot form.
- `wr_idx_o` = `paddr[OFF_W+IDX_W-1:OFF_W]`.
- `wr_tag_o` = `paddr[PHY_ADDR_SIZE-1:OFF_W+IDX_W]`.
- Invalidation:
  - `ifill_resp_i.inv.valid` is registered. `inv_en_o` goes high the next cycle with `inv_idx_o` = `inv.paddr[OFF_W+IDX_W-1:OFF_W]`.
  - Invalidation is accepted in every state.
  - If the invalidated index equals the pending refill index while in REQ or WAIT (or in the WRITE-entry cycle), `stale` is set. The line is then not written, but `done_o` still pulses so control replays the fetch.
  - An invalidation in the same cycle as WRITE to the same index takes effect after the write.

## Timing
- Miss accepted at cycle T → `ifill_req_o.valid` high from T+1.
- Ack at cycle A → request valid low at A+1.
- `resp.valid` at cycle R → `wr_en_o`/`done_o` at R+1, `miss_ready_o` high at R+2.
- Minimum turnaround (ack and valid at T+1) is 3 cycles from acceptance to the next `miss_ready_o`.
- Reset values: state IDLE, `rr`=0, all outputs 0 except `miss_ready_o`=1.
- Reset mid-refill returns to IDLE immediately. A response arriving later is ignored in IDLE.

## Structure
- Add to `sargantana_icache_pkg`: `refill_state_t` {IDLE, REQ, WAIT, WRITE}. Reuse `ifill_req_o_t` and `ifill_resp_i_t`.
- One sub-module: `sargantana_icache_victim_sel`, containing the first-invalid priority encoder, the round-robin pointer, and the one-hot/binary outputs.

## Test plan
- Cold miss, `paddr`=0x1058, `way_valid`=0000, ack 3 cycles after request, valid 2 cycles later → `ifill_req.paddr`=0x1040, `way`=0, then `wr_en` with idx=1, tag=0x1, `wr_way`=0001, and `done_o` at R+1.
- Set full (`way_valid`=1111), 5 back-to-back misses → victims 0,1,2,3,0. With `way_valid`=1011 → victim 2, and `rr` unchanged.
- `kill_i` during WAIT → response consumed, no `wr_en`/`done_o`, `miss_ready_o` high at R+2.
- Invalidation of idx 1 during WAIT for idx 1 → `inv_en_o` idx=1 the next cycle, no `wr_en`, `done_o` pulses. Invalidation of idx 2 instead → normal write.
- Ack and valid in the same cycle as the request → WRITE at T+2, idle at T+3.
- `rst_i` during WAIT, then a late `resp.valid` → no write, `ifill_req.valid`=0, `miss_ready_o`=1.
